// File: rtl/phy_rx_lane_pkg.sv
// Shared constants, types and the round-robin pick helper for the PHY receive
// lane buffer.
package phy_rx_lane_pkg;

  localparam int LANES     = 4;
  localparam int VALID_BIT = 8;
  localparam int LANE_W    = 2;

  typedef logic [LANE_W-1:0] lane_idx_t;

  typedef struct packed {
    logic      found;
    lane_idx_t lane;
  } grant_t;

  // First requesting lane after 'last', checking last+1 .. last+LANES (mod LANES),
  // so the lane granted most recently gets the lowest priority.
  function automatic grant_t rr_pick(input logic [LANES-1:0] req,
                                     input lane_idx_t        last);
    grant_t    g;
    lane_idx_t idx;
    g = '0;
    for (int k = 1; k <= LANES; k++) begin
      idx = last + lane_idx_t'(k);
      if (!g.found && req[idx]) begin
        g.found = 1'b1;
        g.lane  = idx;
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/phy_rx_lane_buffer_if.sv
// Lane inputs and the merged valid/ready output stream of the lane buffer.
interface phy_rx_lane_buffer_if
  import phy_rx_lane_pkg::*;
#(
  parameter int DATA_W = VALID_BIT
);

  logic [DATA_W:0]   data_0;
  logic [DATA_W:0]   data_1;
  logic [DATA_W:0]   data_2;
  logic [DATA_W:0]   data_3;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic [LANE_W-1:0] out_lane;

  // Upstream PHY plus downstream consumer side.
  modport master (
    output data_0, data_1, data_2, data_3, out_ready,
    input  out_data, out_valid, out_lane
  );

  // The lane buffer itself.
  modport slave (
    input  data_0, data_1, data_2, data_3, out_ready,
    output out_data, out_valid, out_lane
  );

endinterface

// File: rtl/lane_fifo.sv
// Single-lane circular FIFO. A push while full is accepted only when the head
// is popped in the same cycle; otherwise the word is ignored here and the
// drop is flagged by the parent.
module lane_fifo #(
  parameter  int DEPTH  = 4,
  parameter  int DATA_W = 8,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = PTR_W + 1
) (
  input  logic              clkf,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output logic              empty,
  output logic              full,
  output logic [CNT_W-1:0]  count
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  cnt;
  logic              push_ok;
  logic              pop_ok;

  assign empty     = (cnt == '0);
  assign full      = (cnt == CNT_W'(DEPTH));
  assign push_ok   = push && (!full || pop);
  assign pop_ok    = pop && !empty;
  assign head_data = mem[rd_ptr];
  assign count     = cnt;

  // Pointer and occupancy update; pointers wrap naturally since DEPTH is a power of 2.
  always_ff @(posedge clkf) begin
    // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      cnt <= cnt + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  // Storage write. When full with a pop, wr_ptr == rd_ptr: the old head is read
  // out at this same edge, so overwriting its slot is safe.
  always_ff @(posedge clkf) begin
    // NOTE: the array is deliberately not reset; the count qualifies every entry.
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/phy_rx_lane_buffer.sv
// Four-lane receive buffer: per-lane FIFOs drained one word per cycle by a
// round-robin arbiter into a registered valid/ready output, with sticky
// per-lane overflow flags and registered almost_full indications.
module phy_rx_lane_buffer
  import phy_rx_lane_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int AF_THRESH = 3,
  parameter int DATA_W    = VALID_BIT
) (
  input  logic                 clkf,
  input  logic                 reset,
  phy_rx_lane_buffer_if.slave  bus,
  input  logic                 err_clr,
  output logic [LANES-1:0]     almost_full,
  output logic [LANES-1:0]     overflow
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] AF_CNT = CNT_W'(AF_THRESH);

  logic [DATA_W:0]   lane_word  [LANES];
  logic [DATA_W-1:0] head       [LANES];
  logic [CNT_W-1:0]  count      [LANES];
  logic [CNT_W-1:0]  count_next [LANES];

  logic [LANES-1:0]  push;
  logic [LANES-1:0]  pop;
  logic [LANES-1:0]  empty;
  logic [LANES-1:0]  full;
  logic [LANES-1:0]  accept;
  logic [LANES-1:0]  drop;
  logic [LANES-1:0]  af_next;

  lane_idx_t         last_grant;
  grant_t            grant;
  logic              loadable;

  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;
  lane_idx_t         out_lane_q;

  assign lane_word[0] = bus.data_0;
  assign lane_word[1] = bus.data_1;
  assign lane_word[2] = bus.data_2;
  assign lane_word[3] = bus.data_3;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign push[i] = lane_word[i][DATA_W];

    lane_fifo #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W)
    ) u_fifo (
      .clkf      (clkf),
      .reset     (reset),
      .push      (push[i]),
      .push_data (lane_word[i][DATA_W-1:0]),
      .pop       (pop[i]),
      .head_data (head[i]),
      .empty     (empty[i]),
      .full      (full[i]),
      .count     (count[i])
    );
  end

  // Arbitration: pick a non-empty lane (registered counts only) when the output can load.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    pop      = '0;
    loadable = !out_valid_q || bus.out_ready;
    grant    = rr_pick(~empty, last_grant);
    if (loadable && grant.found) pop[grant.lane] = 1'b1;
  end

  // Per-lane accept/drop decision and the occupancy after this cycle.
  always_comb begin
    accept  = '0;
    drop    = '0;
    af_next = '0;
    for (int i = 0; i < LANES; i++) begin
      count_next[i] = count[i];
      accept[i]     = push[i] && (!full[i] || pop[i]);
      drop[i]       = push[i] && full[i] && !pop[i];
      count_next[i] = count[i] + CNT_W'(accept[i]) - CNT_W'(pop[i]);
      af_next[i]    = (count_next[i] >= AF_CNT);
    end
  end

  // Output register and arbiter pointer; held while valid and not ready.
  always_ff @(posedge clkf) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_lane_q  <= '0;
      last_grant  <= lane_idx_t'(LANES - 1);
    end else if (loadable) begin
      if (grant.found) begin
        out_valid_q <= 1'b1;
        out_data_q  <= head[grant.lane];
        out_lane_q  <= grant.lane;
        last_grant  <= grant.lane;
      end else begin
        out_valid_q <= 1'b0;
      end
    end
  end

  // Sticky overflow flags (a new drop beats err_clr) and registered almost_full.
  always_ff @(posedge clkf) begin
    if (reset) begin
      overflow    <= '0;
      almost_full <= '0;
    end else begin
      overflow    <= (err_clr ? '0 : overflow) | drop;
      almost_full <= af_next;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_lane  = out_lane_q;

endmodule

// File: tb/tb_phy_rx_lane_buffer.sv
// Bench for phy_rx_lane_buffer: a directed vector table covering the main
// scenarios, then randomized traffic compared with a queue-based model.
module tb_phy_rx_lane_buffer;
  import phy_rx_lane_pkg::*;

  localparam int DEPTH = 4;
  localparam int AF    = 3;
  localparam logic [8:0] N = 9'h000;

  logic       clkf = 1'b0;
  logic       reset;
  logic       err_clr;
  logic [3:0] almost_full;
  logic [3:0] overflow;

  phy_rx_lane_buffer_if #(.DATA_W(8)) bus ();

  phy_rx_lane_buffer #(
    .DEPTH     (DEPTH),
    .AF_THRESH (AF),
    .DATA_W    (8)
  ) dut (
    .clkf        (clkf),
    .reset       (reset),
    .bus         (bus),
    .err_clr     (err_clr),
    .almost_full (almost_full),
    .overflow    (overflow)
  );

  always #5 clkf = ~clkf;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive(input logic rst, input logic [8:0] d0, input logic [8:0] d1,
                       input logic [8:0] d2, input logic [8:0] d3,
                       input logic rdy, input logic clr);
    reset         = rst;
    bus.data_0    = d0;
    bus.data_1    = d1;
    bus.data_2    = d2;
    bus.data_3    = d3;
    bus.out_ready = rdy;
    err_clr       = clr;
  endtask

  task automatic step();
    @(posedge clkf);
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic       rst;
    logic [8:0] d0, d1, d2, d3;
    logic       rdy, clr;
    logic       ev;
    logic [7:0] ed;
    logic [1:0] el;
    logic [3:0] eaf, eov;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic rst, input logic [8:0] d0, input logic [8:0] d1,
                              input logic [8:0] d2, input logic [8:0] d3,
                              input logic rdy, input logic clr, input logic ev,
                              input logic [7:0] ed, input logic [1:0] el,
                              input logic [3:0] eaf, input logic [3:0] eov);
    vec_t v;
    v.rst = rst; v.d0 = d0; v.d1 = d1; v.d2 = d2; v.d3 = d3;
    v.rdy = rdy; v.clr = clr; v.ev = ev; v.ed = ed; v.el = el;
    v.eaf = eaf; v.eov = eov;
    return v;
  endfunction

  // ---------------- behavioural reference model ----------------
  logic [7:0] mq [4][$];
  logic       mv;
  logic [7:0] md;
  int         ml;
  int         mlg;
  logic [3:0] maf;
  logic [3:0] mov;

  task automatic model_step(input logic rst, input logic [8:0] d0, input logic [8:0] d1,
                            input logic [8:0] d2, input logic [8:0] d3,
                            input logic rdy, input logic clr);
    logic [8:0] d [4];
    logic [3:0] drops;
    int         pick;
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    if (rst) begin
      for (int i = 0; i < 4; i++) mq[i].delete();
      mv = 1'b0; md = 8'h00; ml = 0; mlg = 3; maf = 4'h0; mov = 4'h0;
      return;
    end
    pick = -1;
    if (!mv || rdy) begin
      for (int k = 1; k <= 4; k++)
        if (pick < 0 && mq[(mlg + k) % 4].size() > 0) pick = (mlg + k) % 4;
      if (pick >= 0) begin
        md  = mq[pick].pop_front();
        ml  = pick;
        mv  = 1'b1;
        mlg = pick;
      end else begin
        mv = 1'b0;
      end
    end
    drops = 4'h0;
    for (int i = 0; i < 4; i++) begin
      if (d[i][8]) begin
        if (mq[i].size() < DEPTH) mq[i].push_back(d[i][7:0]);
        else drops[i] = 1'b1;
      end
    end
    mov = (clr ? 4'h0 : mov) | drops;
    for (int i = 0; i < 4; i++) maf[i] = (mq[i].size() >= AF);
  endtask

  initial begin
    logic [8:0] rd [4];
    logic       rrdy, rclr, rrst;

    drive(1'b0, N, N, N, N, 1'b0, 1'b0);

    // reset, single push
    tbl.push_back(mk(1, N, N, N, N, 0, 0, 0, 8'h00, 0, 4'h0, 4'h0));
    tbl.push_back(mk(0, N, N, 9'h1A5, N, 1, 0, 0, 8'h00, 0, 4'h0, 4'h0));
    tbl.push_back(mk(0, N, N, N, N, 1, 0, 1, 8'hA5, 2, 4'h0, 4'h0));
    tbl.push_back(mk(0, N, N, N, N, 1, 0, 0, 8'h00, 0, 4'h0, 4'h0));
    // round robin from reset priority
    tbl.push_back(mk(1, N, N, N, N, 1, 0, 0, 8'h00, 0, 4'h0, 4'h0));
    tbl.push_back(mk(0, 9'h110, 9'h111, N, 9'h113, 1, 0, 0, 8'h00, 0, 4'h0, 4'h0));
    tbl.push_back(mk(0, N, N, N, N, 1, 0, 1, 8'h10, 0, 4'h0, 4'h0));
    tbl.push_back(mk(0, N, N, N, N, 1, 0, 1, 8'h11, 1, 4'h0, 4'h0));
    tbl.push_back(mk(0, N, N, N, N, 1, 0, 1, 8'h13, 3, 4'h0, 4'h0));
    tbl.push_back(mk(0, N, N, N, N, 1, 0, 0, 8'h00, 0, 4'h0, 4'h0));
    // backpressure on lane 1
    tbl.push_back(mk(0, N, 9'h1C1, N, N, 0, 0, 0, 8'h00, 0, 4'h0, 4'h0));
    tbl.push_back(mk(0, N, 9'h1C2, N, N, 0, 0, 1, 8'hC1, 1, 4'h0, 4'h0));
    tbl.push_back(mk(0, N, 9'h1C3, N, N, 0, 0, 1, 8'hC1, 1, 4'h0, 4'h0));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(0, N, N, N, N, 0, 0, 1, 8'hC1, 1, 4'h0, 4'h0));
    tbl.push_back(mk(0, N, N, N, N, 1, 0, 1, 8'hC2, 1, 4'h0, 4'h0));
    tbl.push_back(mk(0, N, N, N, N, 1, 0, 1, 8'hC3, 1, 4'h0, 4'h0));
    tbl.push_back(mk(0, N, N, N, N, 1, 0, 0, 8'h00, 0, 4'h0, 4'h0));
    // overflow on lane 0, then err_clr and drain
    tbl.push_back(mk(0, 9'h1A0, N, N, N, 0, 0, 0, 8'h00, 0, 4'h0, 4'h0));
    tbl.push_back(mk(0, 9'h1A1, N, N, N, 0, 0, 1, 8'hA0, 0, 4'h0, 4'h0));
    tbl.push_back(mk(0, 9'h1A2, N, N, N, 0, 0, 1, 8'hA0, 0, 4'h0, 4'h0));
    tbl.push_back(mk(0, 9'h1A3, N, N, N, 0, 0, 1, 8'hA0, 0, 4'h1, 4'h0));
    tbl.push_back(mk(0, 9'h1A4, N, N, N, 0, 0, 1, 8'hA0, 0, 4'h1, 4'h0));
    tbl.push_back(mk(0, 9'h1A5, N, N, N, 0, 0, 1, 8'hA0, 0, 4'h1, 4'h1));
    tbl.push_back(mk(0, N, N, N, N, 0, 1, 1, 8'hA0, 0, 4'h1, 4'h0));
    tbl.push_back(mk(0, N, N, N, N, 1, 0, 1, 8'hA1, 0, 4'h1, 4'h0));
    tbl.push_back(mk(0, N, N, N, N, 1, 0, 1, 8'hA2, 0, 4'h0, 4'h0));
    tbl.push_back(mk(0, N, N, N, N, 1, 0, 1, 8'hA3, 0, 4'h0, 4'h0));
    tbl.push_back(mk(0, N, N, N, N, 1, 0, 1, 8'hA4, 0, 4'h0, 4'h0));
    tbl.push_back(mk(0, N, N, N, N, 1, 0, 0, 8'h00, 0, 4'h0, 4'h0));
    // lane 3 full with a simultaneous pop and push
    tbl.push_back(mk(0, N, N, N, 9'h1B0, 0, 0, 0, 8'h00, 0, 4'h0, 4'h0));
    tbl.push_back(mk(0, N, N, N, 9'h1B1, 0, 0, 1, 8'hB0, 3, 4'h0, 4'h0));
    tbl.push_back(mk(0, N, N, N, 9'h1B2, 0, 0, 1, 8'hB0, 3, 4'h0, 4'h0));
    tbl.push_back(mk(0, N, N, N, 9'h1B3, 0, 0, 1, 8'hB0, 3, 4'h8, 4'h0));
    tbl.push_back(mk(0, N, N, N, 9'h1B4, 0, 0, 1, 8'hB0, 3, 4'h8, 4'h0));
    tbl.push_back(mk(0, N, N, N, 9'h1B5, 1, 0, 1, 8'hB1, 3, 4'h8, 4'h0));
    tbl.push_back(mk(0, N, N, N, N, 1, 0, 1, 8'hB2, 3, 4'h8, 4'h0));
    tbl.push_back(mk(0, N, N, N, N, 1, 0, 1, 8'hB3, 3, 4'h0, 4'h0));
    tbl.push_back(mk(0, N, N, N, N, 1, 0, 1, 8'hB4, 3, 4'h0, 4'h0));
    tbl.push_back(mk(0, N, N, N, N, 1, 0, 1, 8'hB5, 3, 4'h0, 4'h0));
    tbl.push_back(mk(0, N, N, N, N, 1, 0, 0, 8'h00, 0, 4'h0, 4'h0));
    // reset mid-operation discards buffered data and restores lane 0 priority
    tbl.push_back(mk(0, 9'h1E0, 9'h1E1, 9'h1E2, 9'h1E3, 0, 0, 0, 8'h00, 0, 4'h0, 4'h0));
    tbl.push_back(mk(0, N, N, N, N, 0, 0, 1, 8'hE0, 0, 4'h0, 4'h0));
    tbl.push_back(mk(1, N, N, N, N, 0, 0, 0, 8'h00, 0, 4'h0, 4'h0));
    tbl.push_back(mk(0, N, 9'h1F1, 9'h1F2, N, 1, 0, 0, 8'h00, 0, 4'h0, 4'h0));
    tbl.push_back(mk(0, N, N, N, N, 1, 0, 1, 8'hF1, 1, 4'h0, 4'h0));
    tbl.push_back(mk(0, N, N, N, N, 1, 0, 1, 8'hF2, 2, 4'h0, 4'h0));
    tbl.push_back(mk(0, N, N, N, N, 1, 0, 0, 8'h00, 0, 4'h0, 4'h0));

    for (int r = 0; r < tbl.size(); r++) begin
      drive(tbl[r].rst, tbl[r].d0, tbl[r].d1, tbl[r].d2, tbl[r].d3, tbl[r].rdy, tbl[r].clr);
      step();
      check($sformatf("row%0d out_valid", r), 32'(bus.out_valid), 32'(tbl[r].ev));
      if (tbl[r].ev || tbl[r].rst) begin
        check($sformatf("row%0d out_data", r), 32'(bus.out_data), 32'(tbl[r].ed));
        check($sformatf("row%0d out_lane", r), 32'(bus.out_lane), 32'(tbl[r].el));
      end
      check($sformatf("row%0d almost_full", r), 32'(almost_full), 32'(tbl[r].eaf));
      check($sformatf("row%0d overflow", r), 32'(overflow), 32'(tbl[r].eov));
    end

    // ---------------- randomized traffic against the model ----------------
    drive(1'b1, N, N, N, N, 1'b0, 1'b0);
    model_step(1'b1, N, N, N, N, 1'b0, 1'b0);
    step();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 4; i++)
        rd[i] = {($urandom_range(99) < 35) ? 1'b1 : 1'b0, 8'($urandom)};
      rrdy = ($urandom_range(99) < 65);
      rclr = ($urandom_range(99) < 4);
      rrst = ($urandom_range(999) < 5);
      drive(rrst, rd[0], rd[1], rd[2], rd[3], rrdy, rclr);
      model_step(rrst, rd[0], rd[1], rd[2], rd[3], rrdy, rclr);
      step();
      check($sformatf("rnd%0d out_valid", c), 32'(bus.out_valid), 32'(mv));
      if (mv) begin
        check($sformatf("rnd%0d out_data", c), 32'(bus.out_data), 32'(md));
        check($sformatf("rnd%0d out_lane", c), 32'(bus.out_lane), 32'(ml));
      end
      check($sformatf("rnd%0d almost_full", c), 32'(almost_full), 32'(maf));
      check($sformatf("rnd%0d overflow", c), 32'(overflow), 32'(mov));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/phy_rx_lane_buffer.md
Name: phy_rx_lane_buffer

Overview:
Downstream consumer of the PHY receive side. Takes the four 9-bit recovered lane words, each with bit 8 as valid and [7:0] as data, on the clkf domain. It buffers each lane in its own FIFO and drains the lanes one word per cycle through a round-robin arbiter onto a single valid/ready output. The PHY has no backpressure, so per-lane overflow is detected, the word is dropped, and the event is flagged.

Parameters:
DEPTH, 4, entries per lane FIFO; must be a power of 2 and at least 2.
AF_THRESH, 3, occupancy at or above which lane almost_full asserts.
DATA_W, 8, payload width; lane words are DATA_W+1 bits wide.

Ports:
clkf  in  1  single clock (the PHY clk_f domain)
reset  in  1  synchronous, active-high
data_0  in  9  lane 0 word: [8] valid, [7:0] data
data_1  in  9  lane 1 word
data_2  in  9  lane 2 word
data_3  in  9  lane 3 word
out_ready  in  1  consumer accepts out_data this cycle
err_clr  in  1  clears the sticky overflow flags
out_data  out  8  selected payload
out_valid  out  1  out_data/out_lane valid
out_lane  out  2  lane index of out_data
almost_full  out  4  per-lane occupancy >= AF_THRESH
overflow  out  4  sticky per-lane dropped-word flag

Behaviour:
- Reset: all lane FIFOs emptied (pointers and counts = 0). Arbiter pointer last_grant = 3, so lane 0 has first priority. out_valid=0, out_data=0, out_lane=0, almost_full=0, overflow=0. Reset has priority over every other input; reset asserted mid-transfer discards all buffered and output-held data.
- Lane write: in every cycle where data_i[8]=1, data_i[7:0] is pushed if the lane is not full, or if it is full and being popped in that same cycle. The count is then unchanged and the push is accepted.
- Overflow: data_i[8]=1 while the lane is full and not popped → word dropped; overflow[i] is set next cycle and stays set.
- err_clr clears all overflow bits. If a new overflow occurs in the same cycle as err_clr, the set wins.
- data_i[8]=0 → no push; the data bits are ignored.
- Output register is loadable when out_valid=0, or when out_valid=1 and out_ready=1.
- When loadable and at least one lane is non-empty, the arbiter:
  - grants the first non-empty lane searching last_grant+1, +2, +3, +4 (mod 4);
  - pops that lane's head into out_data;
  - sets out_lane to the grant and out_valid=1;
  - sets last_grant to the grant.
- When loadable and all lanes are empty, out_valid goes to 0.
- out_valid=1 and out_ready=0: out_data, out_lane and out_valid are held stable; no pop occurs and last_grant does not change.
- Latency: a word pushed in cycle N can appear on the output in cycle N+1 at the earliest (lane empty, output loadable). A FIFO read is allowed in the same cycle the lane becomes non-empty only through the registered count, so no combinational input-to-output path exists.
- Sustained throughput: 1 word/cycle total when out_ready is held high. Four lanes all valid every cycle therefore overflow; that is expected and flagged.
- Pointers wrap modulo DEPTH. Counts are clog2(DEPTH)+1 bits, so full is count==DEPTH and empty is count==0.
- almost_full[i] is a registered compare of the lane count against AF_THRESH, reflecting the count after the current cycle's push/pop.

Decomposition:
- Shared package/include phy_rx_lane_pkg: LANES=4, the valid-bit index (8), and the lane index width (2).
- One sub-module, lane_fifo. It is instantiated four times and has:
  - ports: clkf, reset, push, push_data, pop, head_data, empty, full, count;
  - behaviour: push-when-full-with-pop handled inside; head_data is combinational from the read pointer.
- The top level holds the arbiter, the output register, overflow and almost_full.

Test Plan:
- Reset, then a single push: data_2=9'h1A5 for one cycle, out_ready=1 → one cycle later out_valid=1, out_data=8'hA5, out_lane=2; the following cycle out_valid=0.
- Round robin: in one cycle push lane0=8'h10, lane1=8'h11, lane3=8'h13, out_ready=1 → outputs in consecutive cycles 10/lane0, 11/lane1, 13/lane3, then out_valid=0.
- Backpressure: queue three words on lane 1 with out_ready=0 → the first word is held stable on the output over 5 cycles. Raise out_ready → the remaining words follow in order, with no duplicate and no loss.
- Overflow: out_ready=0 and push 6 words on lane 0 with DEPTH=4 → 5 words are retained (4 in the FIFO, 1 in the output register). overflow=4'b0001 from the cycle after the 6th push; almost_full[0]=1 once the count reaches 3. Pulse err_clr → overflow=0.
- Full plus simultaneous pop: lane 3 full, out_valid=1, out_ready=1 and data_3 valid in the same cycle → push accepted, count stays 4, overflow[3] stays 0.
- Reset mid-operation: with words buffered on all lanes and out_valid=1, assert reset for 1 cycle → next cycle out_valid=0, almost_full=0 and overflow=0. Subsequent pushes are output starting from lane 0 priority.
